// File: rtl/bp_cfg_buffered_mc.sv
// bp_cfg_buffered_mc: multi-channel buffered front end for one cfg/mem endpoint.
// Per-channel command FIFOs feed a round-robin arbiter. An order FIFO records the
// channel of each issued command so that in-order responses go back to their owner.
// Optional feature macro: BP_CFG_BUFFERED_MC_PERF_EN adds per-channel issue counters.
module bp_cfg_buffered_mc #(
  parameter int num_ch_p          = 2,
  parameter int msg_width_p       = 128,
  parameter int cmd_els_p         = 2,
  parameter int resp_els_p        = 2,
  parameter int max_outstanding_p = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [num_ch_p*msg_width_p-1:0] mem_cmd_i,
  input  logic [num_ch_p-1:0]             mem_cmd_v_i,
  output logic [num_ch_p-1:0]             mem_cmd_ready_o,
  output logic [num_ch_p*msg_width_p-1:0] mem_resp_o,
  output logic [num_ch_p-1:0]             mem_resp_v_o,
  input  logic [num_ch_p-1:0]             mem_resp_yumi_i,
  output logic [msg_width_p-1:0]          ep_cmd_o,
  output logic                            ep_cmd_v_o,
  input  logic                            ep_cmd_yumi_i,
  input  logic [msg_width_p-1:0]          ep_resp_i,
  input  logic                            ep_resp_v_i,
  output logic                            ep_resp_ready_o,
  output logic [num_ch_p*32-1:0]          perf_issue_o
);

  localparam int CH_W = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int CP_W = $clog2(cmd_els_p);
  localparam int CC_W = $clog2(cmd_els_p + 1);
  localparam int RP_W = $clog2(resp_els_p);
  localparam int RC_W = $clog2(resp_els_p + 1);
  localparam int OP_W = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int OC_W = $clog2(max_outstanding_p + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} arb_state_e;

  logic [msg_width_p-1:0] w_cmd_head [num_ch_p];
  logic [num_ch_p-1:0]    w_cmd_empty;
  logic [num_ch_p-1:0]    w_cmd_pop;

  arb_state_e             r_state, w_state_nxt;
  logic [CH_W-1:0]        r_grant, w_grant, r_rr;
  logic                   w_gnt_v, w_issue, w_found;
  logic [CH_W:0]          w_scan;

  logic [CH_W-1:0]        r_ord_q [max_outstanding_p];
  logic [OP_W-1:0]        r_ord_rd, r_ord_wr;
  logic [OC_W-1:0]        r_ord_cnt;
  logic                   w_ord_full;
  logic [CH_W-1:0]        w_ord_head;

  logic [msg_width_p-1:0] r_resp_q [resp_els_p];
  logic [RP_W-1:0]        r_resp_rd, r_resp_wr;
  logic [RC_W-1:0]        r_resp_cnt;
  logic                   w_resp_push, w_resp_pop, w_resp_nonempty;
  logic [num_ch_p-1:0]    w_resp_v;

  for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
    logic [msg_width_p-1:0] r_mem [cmd_els_p];
    logic [CP_W-1:0]        r_rd, r_wr;
    logic [CC_W-1:0]        r_cnt;
    logic                   w_push;

    assign mem_cmd_ready_o[c] = (r_cnt != CC_W'(cmd_els_p));
    assign w_push             = mem_cmd_v_i[c] & mem_cmd_ready_o[c];
    assign w_cmd_empty[c]     = (r_cnt == '0);
    assign w_cmd_head[c]      = r_mem[r_rd];
    assign w_cmd_pop[c]       = w_issue & (w_grant == CH_W'(c));

    // Command FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push)
          r_wr <= (r_wr == CP_W'(cmd_els_p - 1)) ? '0 : r_wr + CP_W'(1);
        if (w_cmd_pop[c])
          r_rd <= (r_rd == CP_W'(cmd_els_p - 1)) ? '0 : r_rd + CP_W'(1);
        if (w_push && !w_cmd_pop[c])
          r_cnt <= r_cnt + CC_W'(1);
        else if (!w_push && w_cmd_pop[c])
          r_cnt <= r_cnt - CC_W'(1);
      end
    end

    // Command payload storage, no reset needed
    always_ff @(posedge clk_i) begin
      if (w_push)
        r_mem[r_wr] <= mem_cmd_i[c*msg_width_p +: msg_width_p];
    end
  end

  // Arbiter: round-robin pick in IDLE, hold the grant in LOCKED until yumi
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = r_grant;
    w_gnt_v     = 1'b0;
    w_found     = 1'b0;
    w_scan      = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_ord_full) begin
          for (int i = 0; i < num_ch_p; i++) begin
            w_scan = {1'b0, r_rr} + (CH_W+1)'(i);
            if (w_scan >= (CH_W+1)'(num_ch_p))
              w_scan = w_scan - (CH_W+1)'(num_ch_p);
            if (!w_found && !w_cmd_empty[w_scan[CH_W-1:0]]) begin
              w_found = 1'b1;
              w_grant = w_scan[CH_W-1:0];
            end
          end
        end
        w_gnt_v = w_found;
        if (w_found && !ep_cmd_yumi_i)
          w_state_nxt = ST_LOCKED;
      end
      default: begin
        w_gnt_v = 1'b1;
        if (ep_cmd_yumi_i)
          w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_issue    = w_gnt_v & ep_cmd_yumi_i;
  assign ep_cmd_v_o = w_gnt_v;
  assign ep_cmd_o   = w_cmd_head[w_grant];

  // Arbiter state, held grant and round-robin pointer
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant;
      if (w_issue)
        r_rr <= (w_grant == CH_W'(num_ch_p - 1)) ? '0 : w_grant + CH_W'(1);
    end
  end

  assign w_ord_full = (r_ord_cnt == OC_W'(max_outstanding_p));
  assign w_ord_head = r_ord_q[r_ord_rd];

  // Order FIFO control: push on issue, pop on response consume
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ord_rd  <= '0;
      r_ord_wr  <= '0;
      r_ord_cnt <= '0;
    end else begin
      if (w_issue)
        r_ord_wr <= (r_ord_wr == OP_W'(max_outstanding_p - 1)) ? '0 : r_ord_wr + OP_W'(1);
      if (w_resp_pop)
        r_ord_rd <= (r_ord_rd == OP_W'(max_outstanding_p - 1)) ? '0 : r_ord_rd + OP_W'(1);
      if (w_issue && !w_resp_pop)
        r_ord_cnt <= r_ord_cnt + OC_W'(1);
      else if (!w_issue && w_resp_pop)
        r_ord_cnt <= r_ord_cnt - OC_W'(1);
    end
  end

  // Order FIFO storage of issuing channel ids
  always_ff @(posedge clk_i) begin
    if (w_issue)
      r_ord_q[r_ord_wr] <= w_grant;
  end

  assign ep_resp_ready_o = (r_resp_cnt != RC_W'(resp_els_p));
  assign w_resp_push     = ep_resp_v_i & ep_resp_ready_o;
  assign w_resp_nonempty = (r_resp_cnt != '0);
  assign w_resp_pop      = w_resp_nonempty & mem_resp_yumi_i[w_ord_head];

  // Response FIFO control
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_resp_rd  <= '0;
      r_resp_wr  <= '0;
      r_resp_cnt <= '0;
    end else begin
      if (w_resp_push)
        r_resp_wr <= (r_resp_wr == RP_W'(resp_els_p - 1)) ? '0 : r_resp_wr + RP_W'(1);
      if (w_resp_pop)
        r_resp_rd <= (r_resp_rd == RP_W'(resp_els_p - 1)) ? '0 : r_resp_rd + RP_W'(1);
      if (w_resp_push && !w_resp_pop)
        r_resp_cnt <= r_resp_cnt + RC_W'(1);
      else if (!w_resp_push && w_resp_pop)
        r_resp_cnt <= r_resp_cnt - RC_W'(1);
    end
  end

  // Response payload storage
  always_ff @(posedge clk_i) begin
    if (w_resp_push)
      r_resp_q[r_resp_wr] <= ep_resp_i;
  end

  // Head response is offered only to the channel that issued it
  always_comb begin
    w_resp_v = '0;
    if (w_resp_nonempty)
      w_resp_v[w_ord_head] = 1'b1;
  end

  assign mem_resp_v_o = w_resp_v;
  assign mem_resp_o   = {num_ch_p{r_resp_q[r_resp_rd]}};

`ifdef BP_CFG_BUFFERED_MC_PERF_EN
  logic [31:0] r_perf [num_ch_p];

  // Saturating per-channel issue counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_ch_p; c++)
        r_perf[c] <= '0;
    end else begin
      for (int c = 0; c < num_ch_p; c++)
        if (w_cmd_pop[c] && (r_perf[c] != 32'hFFFF_FFFF))
          r_perf[c] <= r_perf[c] + 32'd1;
    end
  end

  for (genvar c = 0; c < num_ch_p; c++) begin : g_perf
    assign perf_issue_o[c*32 +: 32] = r_perf[c];
  end
`else
  assign perf_issue_o = '0;
`endif

  a_cmd_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ep_cmd_yumi_i |-> ep_cmd_v_o);
  a_resp_needs_order: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ep_resp_v_i |-> (r_ord_cnt != '0));
  a_resp_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (mem_resp_yumi_i & ~mem_resp_v_o) == '0);

endmodule

// File: tb/tb_bp_cfg_buffered_mc.sv
// tb_bp_cfg_buffered_mc: directed bench for bp_cfg_buffered_mc (2 channels, 128b messages).
// A background endpoint/consumer model logs issued and consumed messages.
module tb_bp_cfg_buffered_mc;
  localparam int NCH = 2;
  localparam int MW  = 128;

  logic             clk_i = 1'b0;
  logic             reset_n_i = 1'b1;
  logic [NCH*MW-1:0] mem_cmd_i = '0;
  logic [NCH-1:0]   mem_cmd_v_i = '0;
  logic [NCH-1:0]   mem_cmd_ready_o;
  logic [NCH*MW-1:0] mem_resp_o;
  logic [NCH-1:0]   mem_resp_v_o;
  logic [NCH-1:0]   mem_resp_yumi_i = '0;
  logic [MW-1:0]    ep_cmd_o;
  logic             ep_cmd_v_o;
  logic             ep_cmd_yumi_i = 1'b0;
  logic [MW-1:0]    ep_resp_i = '0;
  logic             ep_resp_v_i = 1'b0;
  logic             ep_resp_ready_o;
  logic [NCH*32-1:0] perf_issue_o;

  bp_cfg_buffered_mc #(
    .num_ch_p(NCH), .msg_width_p(MW), .cmd_els_p(2), .resp_els_p(2), .max_outstanding_p(4)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i),
    .ep_cmd_o(ep_cmd_o), .ep_cmd_v_o(ep_cmd_v_o), .ep_cmd_yumi_i(ep_cmd_yumi_i),
    .ep_resp_i(ep_resp_i), .ep_resp_v_i(ep_resp_v_i), .ep_resp_ready_o(ep_resp_ready_o),
    .perf_issue_o(perf_issue_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef BP_CFG_BUFFERED_MC_PERF_EN
  localparam logic [31:0] PERF_CH0_AFTER3 = 32'd3;
`else
  localparam logic [31:0] PERF_CH0_AFTER3 = 32'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic          auto_yumi = 1'b0;
  int            credit    = 0;
  logic [NCH-1:0] cons_mask = '0;
  logic          ch1_seen  = 1'b0;
  logic [MW-1:0] issued[$];
  logic [MW-1:0] pend[$];
  logic [MW-1:0] cons_data[$];
  int            cons_ch[$];

  task automatic check_val(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] iss_at(input int k);
    return (k < issued.size()) ? issued[k] : 'x;
  endfunction
  function automatic logic [MW-1:0] cdat_at(input int k);
    return (k < cons_data.size()) ? cons_data[k] : 'x;
  endfunction
  function automatic int cch_at(input int k);
    return (k < cons_ch.size()) ? cons_ch[k] : -1;
  endfunction

  // Endpoint and consumer model, evaluated at the falling edge
  initial begin
    forever begin
      @(negedge clk_i);
      if (pend.size() > 0 && credit > 0 && ep_resp_ready_o === 1'b1) begin
        ep_resp_v_i = 1'b1;
        ep_resp_i   = pend.pop_front();
        credit--;
      end else begin
        ep_resp_v_i = 1'b0;
      end
      ep_cmd_yumi_i = auto_yumi && (ep_cmd_v_o === 1'b1);
      if (ep_cmd_yumi_i) begin
        issued.push_back(ep_cmd_o);
        pend.push_back(ep_cmd_o);
      end
      mem_resp_yumi_i = mem_resp_v_o & cons_mask;
      if (mem_resp_v_o[1] === 1'b1) ch1_seen = 1'b1;
      if (mem_resp_yumi_i != '0) begin
        cons_ch.push_back(mem_resp_yumi_i[1] ? 1 : 0);
        cons_data.push_back(mem_resp_o[(mem_resp_yumi_i[1] ? 1 : 0)*MW +: MW]);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    auto_yumi   = 1'b0;
    credit      = 0;
    cons_mask   = '0;
    mem_cmd_v_i = '0;
    reset_n_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    issued.delete(); pend.delete(); cons_data.delete(); cons_ch.delete();
    ch1_seen  = 1'b0;
    reset_n_i = 1'b1;
  endtask

  task automatic send(input int ch, input logic [MW-1:0] d);
    int n;
    n = 0;
    while (mem_cmd_ready_o[ch] !== 1'b1 && n < 100) begin
      run(1);
      n++;
    end
    if (n >= 100) check_val("send_ready_timeout", MW'(mem_cmd_ready_o[ch]), MW'(1));
    mem_cmd_i[ch*MW +: MW] = d;
    mem_cmd_v_i[ch] = 1'b1;
    run(1);
    mem_cmd_v_i[ch] = 1'b0;
  endtask

  task automatic load2(input logic [MW-1:0] d0, input logic [MW-1:0] d1);
    mem_cmd_i   = {d1, d0};
    mem_cmd_v_i = 2'b11;
    run(1);
    mem_cmd_v_i = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] exp_d [4];
    int            exp_c [4];
    #2;
    do_reset();

    // Reset values
    check_val("rst_cmd_ready", MW'(mem_cmd_ready_o), MW'(2'b11));
    check_val("rst_resp_v", MW'(mem_resp_v_o), MW'(0));
    check_val("rst_ep_cmd_v", MW'(ep_cmd_v_o), MW'(0));
    check_val("rst_ep_resp_ready", MW'(ep_resp_ready_o), MW'(1));
    check_val("rst_perf", MW'(perf_issue_o), MW'(0));

    // 1: ch0 A,B,C with immediate yumi and echo
    do_reset();
    auto_yumi = 1'b1; credit = 1000; cons_mask = 2'b11;
    send(0, 128'hA); send(0, 128'hB); send(0, 128'hC);
    run(20);
    check_val("t1_cons_cnt", MW'(cons_data.size()), MW'(3));
    exp_d[0] = 128'hA; exp_d[1] = 128'hB; exp_d[2] = 128'hC;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("t1_data%0d", k), cdat_at(k), exp_d[k]);
      check_val($sformatf("t1_ch%0d", k), MW'(cch_at(k)), MW'(0));
    end
    check_val("t1_ch1_never_v", MW'(ch1_seen), MW'(0));

    // 2: round-robin between two loaded channels
    do_reset();
    credit = 1000; cons_mask = 2'b11;
    load2(128'h10, 128'h20);
    load2(128'h11, 128'h21);
    auto_yumi = 1'b1;
    run(30);
    exp_d[0] = 128'h10; exp_d[1] = 128'h20; exp_d[2] = 128'h11; exp_d[3] = 128'h21;
    exp_c[0] = 0; exp_c[1] = 1; exp_c[2] = 0; exp_c[3] = 1;
    check_val("t2_issue_cnt", MW'(issued.size()), MW'(4));
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("t2_issue%0d", k), iss_at(k), exp_d[k]);
      check_val($sformatf("t2_resp_ch%0d", k), MW'(cch_at(k)), MW'(exp_c[k]));
      check_val($sformatf("t2_resp_d%0d", k), cdat_at(k), exp_d[k]);
    end

    // 3: LOCKED grant is held while yumi is withheld
    do_reset();
    credit = 1000; cons_mask = 2'b11;
    send(0, 128'h3A);
    check_val("t3_latency_v", MW'(ep_cmd_v_o), MW'(1));
    check_val("t3_latency_d", ep_cmd_o, 128'h3A);
    send(1, 128'h3B);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("t3_hold_v%0d", k), MW'(ep_cmd_v_o), MW'(1));
      check_val($sformatf("t3_hold_d%0d", k), ep_cmd_o, 128'h3A);
      run(1);
    end
    auto_yumi = 1'b1;
    run(10);
    check_val("t3_issue0", iss_at(0), 128'h3A);
    check_val("t3_issue1", iss_at(1), 128'h3B);

    // 4: outstanding limit of 4 with a silent endpoint
    do_reset();
    auto_yumi = 1'b1; credit = 0; cons_mask = 2'b11;
    load2(128'h40, 128'h50);
    load2(128'h41, 128'h51);
    send(0, 128'h42); send(0, 128'h43);
    run(10);
    check_val("t4_issue_cnt4", MW'(issued.size()), MW'(4));
    check_val("t4_v_low_full", MW'(ep_cmd_v_o), MW'(0));
    check_val("t4_ch0_ready", MW'(mem_cmd_ready_o[0]), MW'(0));
    credit = 1;
    run(8);
    check_val("t4_cons_d", cdat_at(0), 128'h40);
    check_val("t4_cons_ch", MW'(cch_at(0)), MW'(0));
    check_val("t4_issue_cnt5", MW'(issued.size()), MW'(5));
    check_val("t4_issue5", iss_at(4), 128'h42);
    check_val("t4_v_low_again", MW'(ep_cmd_v_o), MW'(0));

    // 5: stalled ch1 consumer backs up the response FIFO
    do_reset();
    auto_yumi = 1'b1; credit = 1000; cons_mask = 2'b01;
    send(1, 128'h60); send(1, 128'h61); send(1, 128'h62);
    run(15);
    check_val("t5_ready_low", MW'(ep_resp_ready_o), MW'(0));
    check_val("t5_resp_v", MW'(mem_resp_v_o), MW'(2'b10));
    cons_mask = 2'b10;
    run(1);
    cons_mask = 2'b00;
    check_val("t5_ready_back", MW'(ep_resp_ready_o), MW'(1));
    check_val("t5_cons_cnt", MW'(cons_data.size()), MW'(1));
    check_val("t5_cons_d", cdat_at(0), 128'h60);
    check_val("t5_cons_ch", MW'(cch_at(0)), MW'(1));

    // 6: asynchronous reset mid-burst, then counter restart
    do_reset();
    auto_yumi = 1'b1; credit = 0; cons_mask = 2'b11;
    load2(128'h70, 128'h80);
    load2(128'h71, 128'h81);
    run(1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_val("t6_cmd_ready", MW'(mem_cmd_ready_o), MW'(2'b11));
    check_val("t6_resp_v", MW'(mem_resp_v_o), MW'(0));
    check_val("t6_ep_cmd_v", MW'(ep_cmd_v_o), MW'(0));
    check_val("t6_ep_resp_ready", MW'(ep_resp_ready_o), MW'(1));
    check_val("t6_perf_zero", MW'(perf_issue_o), MW'(0));
    do_reset();
    auto_yumi = 1'b1; credit = 1000; cons_mask = 2'b11;
    send(0, 128'h90); send(0, 128'h91); send(0, 128'h92);
    run(15);
    check_val("t6_issue_cnt", MW'(issued.size()), MW'(3));
    check_val("t6_perf_ch0", MW'(perf_issue_o[31:0]), MW'(PERF_CH0_AFTER3));
    check_val("t6_perf_ch1", MW'(perf_issue_o[63:32]), MW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
